spi_slave: RTL and testbench
============================

Name: spi_slave

Overview:
- SPI slave endpoint. It is the responder to the team's 4-select SPI master; one instance sits behind each ss_n line.
- Oversamples sck/ss_n/mosi on the system clock and deserialises one LSB-first frame of TX_NBITS bits.
- Presents write transactions on a parallel strobe interface. For read frames, it fetches data from a register-file port and returns it on miso during the frame's data field.

Parameters:
DWIDTH, 8, data field width in bits
AWIDTH, 8, address field width in bits
TX_NBITS, DWIDTH+AWIDTH+3, frame length in bits (derived; do not override)

Ports:
clk  in  1  system clock (one clock)
rst  in  1  reset, synchronous, active-high
mode  in  2  SPI mode {cpol,cpha}; static while ss_n low
sck  in  1  serial clock from master, asynchronous to clk
ss_n  in  1  slave select, active-low, asynchronous
mosi  in  1  serial data in, asynchronous
miso  out  1  serial data out; 'z when not selected
rx_valid  out  1  one-cycle pulse: complete frame received
rx_write  out  1  frame bit 0 (1=write, 0=read), valid with rx_valid
rx_size  out  2  frame bits [2:1], valid with rx_valid
rx_addr  out  AWIDTH  frame bits [AWIDTH+2:3], valid with rx_valid
rx_data  out  DWIDTH  frame bits [TX_NBITS-1:AWIDTH+3], valid with rx_valid
rd_req  out  1  one-cycle read request to register file
rd_addr  out  AWIDTH  address for rd_req
rd_data  in  DWIDTH  read data, valid exactly 1 clk after rd_req
frame_err  out  1  one-cycle pulse: ss_n rose before TX_NBITS bits were sampled

Behaviour:
- Reset (rst=1 at a clk edge):
  - All registered outputs go to 0: rx_valid, rx_write, rx_size, rx_addr, rx_data, rd_req, rd_addr, frame_err.
  - FSM goes to IDLE. Bit counter, shift registers and synchronisers clear.
  - miso is 'z.
  - Reset mid-frame discards the frame silently: no rx_valid, no frame_err.
- Synchronisation: sck, ss_n and mosi each pass through a 2-flop synchroniser.
  - A third flop on sck provides edge detection.
  - An sck edge is recognised 3 clk after it occurs.
- Edge selection:
  - Sample edge is rising sck when cpol==cpha, falling otherwise.
  - The change edge is the opposite edge.
- Timing requirement: the sck half-period must be >= 4 clk cycles. This is the master default. Shorter half-periods are unsupported.
- Frame format: LSB first. Bit 0 is write, bits [2:1] size, then addr, then data.
- FSM states:
  - IDLE: ss_n_sync=1, miso='z. Transition to RX on ss_n_sync falling edge. On that transition, clear bit_cnt and rx shift register; miso drives 0.
  - RX:
    - On each sample edge, shift mosi_sync into the rx register MSB, then right-shift; increment bit_cnt (6 bits).
    - When bit_cnt reaches AWIDTH+3 and bit 0 of the frame was 0, pulse rd_req for one clk with rd_addr = received addr. Then go to RDLOAD.
    - When bit_cnt reaches TX_NBITS, go to DONE.
    - If ss_n_sync rises first, pulse frame_err, go to IDLE, and drive no rx outputs.
  - RDLOAD: single cycle. Capture rd_data into the tx shift register; return to RX.
  - DONE:
    - Pulse rx_valid for one clk with all rx_* fields, which hold until the next rx_valid.
    - Wait in DONE, ignoring extra sck edges and asserting no further strobes, until ss_n_sync rises; then go to IDLE.
- miso behaviour:
  - Driven only while ss_n_sync=0; 'z otherwise.
  - Outputs tx shift register bit 0. The register shifts right on each change edge occurring after RDLOAD.
  - For write frames, and before read data is loaded, miso=0.
  - Data bit k is therefore valid before the sample edge of frame bit AWIDTH+3+k.
- Simultaneous events:
  - ss_n rising in the same clk as the final sample edge counts the bit. The frame completes: rx_valid fires, frame_err does not.
  - ss_n falling while in DONE (no gap) is illegal. The master guarantees at least one idle clk.

Test Plan:
1. Mode 00, write frame: write=1, size=2'b10, addr=8'h5A, data=8'hC3, 19 bits -> one rx_valid pulse with rx_write=1, rx_size=2, rx_addr=5A, rx_data=C3; no rd_req; miso=0 throughout the frame.
2. Mode 11, read frame: addr=8'h3C, rd_data returns 8'hA5 -> rd_req pulses once with rd_addr=3C after the 11th sample edge; miso carries 1,0,1,0,0,1,0,1 over data bits; rx_valid with rx_write=0.
3. Modes 01 and 10, write frame: addr=8'hFF, data=8'h01 -> fields decode correctly in both modes (edge selection check).
4. ss_n released after 10 bits -> frame_err pulses once; rx_valid never asserts; the next full frame decodes correctly.
5. rst asserted at bit 7 of a frame, then a full frame is sent -> no strobes for the aborted frame; the second frame yields a correct rx_valid; miso='z during reset.
6. 25 sck cycles within one ss_n window -> exactly one rx_valid, from bits 0..18; bits 19..24 are ignored.

Source files
------------

// File: rtl/spi_slave.sv
// SPI slave endpoint: oversamples the SPI pins on clk, deserialises one LSB-first frame
// {data, addr, size, write} and presents it on a strobe interface. Read frames fetch data
// from a register-file port and return it on miso during the frame's data field.
module spi_slave #(
  parameter int unsigned DWIDTH   = 8,
  parameter int unsigned AWIDTH   = 8,
  parameter int unsigned TX_NBITS = DWIDTH + AWIDTH + 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic              sck,
  input  logic              ss_n,
  input  logic              mosi,
  output logic              miso,
  output logic              rx_valid,
  output logic              rx_write,
  output logic [1:0]        rx_size,
  output logic [AWIDTH-1:0] rx_addr,
  output logic [DWIDTH-1:0] rx_data,
  output logic              rd_req,
  output logic [AWIDTH-1:0] rd_addr,
  input  logic [DWIDTH-1:0] rd_data,
  output logic              frame_err
);

  localparam int unsigned CntW = 6;
  localparam logic [CntW-1:0] RdCnt  = CntW'(AWIDTH + 3);
  localparam logic [CntW-1:0] EndCnt = CntW'(TX_NBITS);

  typedef enum logic [1:0] {StIdle, StRx, StRdLoad, StDone} state_e;

  // Pin synchronisers; the third flop of sck/ss_n holds the previous synced value
  logic [2:0] sck_q, ss_n_q;
  logic [1:0] mosi_q;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [TX_NBITS-1:0]   rx_q, rx_d;
  logic [DWIDTH-1:0]     tx_q, tx_d;
  logic                  loaded_q, loaded_d;
  logic                  rd_req_q, rd_req_d;
  logic [AWIDTH-1:0]     rd_addr_q, rd_addr_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  rx_write_q, rx_write_d;
  logic [1:0]            rx_size_q, rx_size_d;
  logic [AWIDTH-1:0]     rx_addr_q, rx_addr_d;
  logic [DWIDTH-1:0]     rx_data_q, rx_data_d;
  logic                  frame_err_q, frame_err_d;

  logic                  sck_rise, sck_fall, sample_edge, change_edge;
  logic                  ss_n_sync, ss_n_fall;
  logic [TX_NBITS-1:0]   rx_shift;
  logic [CntW-1:0]       cnt_inc;

  assign sck_rise    = sck_q[1] & ~sck_q[2];
  assign sck_fall    = ~sck_q[1] & sck_q[2];
  assign sample_edge = (mode[1] == mode[0]) ? sck_rise : sck_fall;
  assign change_edge = (mode[1] == mode[0]) ? sck_fall : sck_rise;
  assign ss_n_sync   = ss_n_q[1];
  assign ss_n_fall   = ss_n_q[2] & ~ss_n_q[1];
  assign rx_shift    = {mosi_q[1], rx_q[TX_NBITS-1:1]};
  assign cnt_inc     = cnt_q + 1'b1;

  // Synchronisers and all FSM/datapath state
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_q       <= '0;
      ss_n_q      <= '0;
      mosi_q      <= '0;
      state_q     <= StIdle;
      cnt_q       <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      loaded_q    <= 1'b0;
      rd_req_q    <= 1'b0;
      rd_addr_q   <= '0;
      rx_valid_q  <= 1'b0;
      rx_write_q  <= 1'b0;
      rx_size_q   <= '0;
      rx_addr_q   <= '0;
      rx_data_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      sck_q       <= {sck_q[1:0], sck};
      ss_n_q      <= {ss_n_q[1:0], ss_n};
      mosi_q      <= {mosi_q[0], mosi};
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      loaded_q    <= loaded_d;
      rd_req_q    <= rd_req_d;
      rd_addr_q   <= rd_addr_d;
      rx_valid_q  <= rx_valid_d;
      rx_write_q  <= rx_write_d;
      rx_size_q   <= rx_size_d;
      rx_addr_q   <= rx_addr_d;
      rx_data_q   <= rx_data_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Next-state logic: frame reception, read fetch and strobe generation
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    loaded_d    = loaded_q;
    rd_req_d    = 1'b0;
    rd_addr_d   = rd_addr_q;
    rx_valid_d  = 1'b0;
    rx_write_d  = rx_write_q;
    rx_size_d   = rx_size_q;
    rx_addr_d   = rx_addr_q;
    rx_data_d   = rx_data_q;
    frame_err_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ss_n_fall) begin
          state_d  = StRx;
          cnt_d    = '0;
          rx_d     = '0;
          tx_d     = '0;
          loaded_d = 1'b0;
        end
      end
      StRx: begin
        // A sample edge wins over ss_n release so a final bit coinciding with release counts
        if (sample_edge) begin
          rx_d  = rx_shift;
          cnt_d = cnt_inc;
          if (cnt_inc == EndCnt) begin
            state_d    = StDone;
            rx_valid_d = 1'b1;
            rx_write_d = rx_shift[0];
            rx_size_d  = rx_shift[2:1];
            rx_addr_d  = rx_shift[AWIDTH+2:3];
            rx_data_d  = rx_shift[TX_NBITS-1:AWIDTH+3];
          end else if (cnt_inc == RdCnt && !rx_shift[DWIDTH]) begin
            // Header sits in the top AWIDTH+3 bits after AWIDTH+3 shifts
            rd_req_d  = 1'b1;
            rd_addr_d = rx_shift[DWIDTH+3 +: AWIDTH];
          end
        end else if (ss_n_sync) begin
          state_d     = StIdle;
          frame_err_d = 1'b1;
        end else if (rd_req_q) begin
          // rd_data is valid in the cycle after rd_req, which is the RDLOAD cycle
          state_d = StRdLoad;
        end else if (change_edge && loaded_q && cnt_q > RdCnt) begin
          // The first change edge after loading presents data bit 0; shift on later ones
          tx_d = tx_q >> 1;
        end
      end
      StRdLoad: begin
        tx_d     = rd_data;
        loaded_d = 1'b1;
        state_d  = StRx;
      end
      StDone: begin
        if (ss_n_sync) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign miso      = (state_q != StIdle && !ss_n_sync) ? tx_q[0] : 1'bz;
  assign rx_valid  = rx_valid_q;
  assign rx_write  = rx_write_q;
  assign rx_size   = rx_size_q;
  assign rx_addr   = rx_addr_q;
  assign rx_data   = rx_data_q;
  assign rd_req    = rd_req_q;
  assign rd_addr   = rd_addr_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: a behavioural SPI master drives frames in all four
// modes, a scoreboard holds expected rx/rd strobes, and miso is checked at sample edges.
module tb_spi_slave;

  localparam int DW   = 8;
  localparam int AW   = 8;
  localparam int NB   = DW + AW + 3;
  localparam int Half = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    mode = 2'b00;
  logic          sck = 1'b0;
  logic          ss_n = 1'b1;
  logic          mosi = 1'b0;
  wire           miso;
  logic          rx_valid, rx_write, rd_req, frame_err;
  logic [1:0]    rx_size;
  logic [AW-1:0] rx_addr, rd_addr;
  logic [DW-1:0] rx_data, rd_data;

  // Released miso reads high so an undriven line is distinguishable from a driven 0
  pullup (miso);

  spi_slave #(.DWIDTH(DW), .AWIDTH(AW)) dut (
    .clk(clk), .rst(rst), .mode(mode), .sck(sck), .ss_n(ss_n), .mosi(mosi), .miso(miso),
    .rx_valid(rx_valid), .rx_write(rx_write), .rx_size(rx_size), .rx_addr(rx_addr),
    .rx_data(rx_data), .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          w;
    logic [1:0]    sz;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } frame_t;

  frame_t        exp_q[$];
  logic [AW-1:0] rd_q[$];
  logic [DW-1:0] rd_val = '0;
  int n_vec = 0, n_err = 0, n_rxv = 0, n_rd = 0, n_ferr = 0;

  // Register file: data valid exactly one clk after rd_req, garbage otherwise
  always @(posedge clk) rd_data <= rd_req ? rd_val : DW'($urandom);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Strobe monitor / scoreboard
  always @(negedge clk) begin
    if (rx_valid) begin
      n_rxv++;
      if (exp_q.size() == 0) chk("rx_unexpected", 1, 0);
      else begin
        frame_t f;
        f = exp_q.pop_front();
        chk("rx_write", rx_write, f.w);
        chk("rx_size", rx_size, f.sz);
        chk("rx_addr", rx_addr, f.a);
        chk("rx_data", rx_data, f.d);
      end
    end
    if (rd_req) begin
      n_rd++;
      if (rd_q.size() == 0) chk("rd_unexpected", 1, 0);
      else chk("rd_addr", rd_addr, rd_q.pop_front());
    end
    if (frame_err) n_ferr++;
  end

  task automatic clk_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Master: clocks nsck bits; rst_at >= 0 asserts reset before that bit and abandons the frame
  task automatic spi_frame(input logic [1:0] m, input logic w, input logic [1:0] sz,
                           input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input int nsck, input int rst_at);
    logic [NB-1:0] f;
    logic [63:0]   bits;
    logic          exp_bit;
    int            rd0;
    f = {d, a, sz, w};
    bits = {$urandom, $urandom};
    bits[NB-1:0] = f;
    if (rst_at < 0 && nsck >= NB) exp_q.push_back({w, sz, a, d});
    if (rst_at < 0 && !w && nsck >= AW + 3) rd_q.push_back(a);
    mode = m;
    sck  = m[1];
    clk_wait(4);
    chk("miso_released_idle", miso, 1);
    rd0  = n_rd;
    ss_n = 1'b0;
    if (!m[0]) mosi = bits[0];
    clk_wait(Half);
    for (int i = 0; i < nsck; i++) begin
      if (i == rst_at) begin
        rst = 1'b1;
        clk_wait(2);
        chk("miso_released_rst", miso, 1);
        ss_n = 1'b1;
        sck  = m[1];
        clk_wait(2);
        rst = 1'b0;
        clk_wait(6);
        return;
      end
      if (m[0]) begin
        sck  = ~sck;
        mosi = bits[i];
        clk_wait(Half);
      end
      // Just before the sample edge: check what the DUT presents
      if (i < NB) begin
        exp_bit = (!w && i >= AW + 3) ? rd_val[i-AW-3] : 1'b0;
        chk($sformatf("miso_bit%0d", i), miso, exp_bit);
      end
      if (!w && i == AW + 2) chk("rd_req_early", n_rd - rd0, 0);
      if (!w && i == AW + 3) chk("rd_req_once", n_rd - rd0, 1);
      sck = ~sck;
      clk_wait(Half);
      if (!m[0]) begin
        sck  = ~sck;
        mosi = bits[i+1];
        clk_wait(Half);
      end
    end
    ss_n = 1'b1;
    sck  = m[1];
    clk_wait(8);
  endtask

  initial begin
    clk_wait(3);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_write", rx_write, 0);
    chk("rst_rx_size", rx_size, 0);
    chk("rst_rx_addr", rx_addr, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_rd_req", rd_req, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_miso", miso, 1);
    rst = 1'b0;
    clk_wait(4);

    // Mode 00 write frame
    spi_frame(2'b00, 1'b1, 2'b10, 8'h5A, 8'hC3, NB, -1);
    chk("t1_rx_count", n_rxv, 1);
    chk("t1_rd_count", n_rd, 0);
    chk("t1_rx_addr_hold", rx_addr, 8'h5A);

    // Mode 11 read frame
    rd_val = 8'hA5;
    spi_frame(2'b11, 1'b0, 2'b01, 8'h3C, 8'h00, NB, -1);
    chk("t2_rx_count", n_rxv, 2);
    chk("t2_rd_count", n_rd, 1);
    chk("t2_rx_write", rx_write, 0);

    // Modes 01 and 10 write frames
    spi_frame(2'b01, 1'b1, 2'b00, 8'hFF, 8'h01, NB, -1);
    spi_frame(2'b10, 1'b1, 2'b11, 8'hFF, 8'h01, NB, -1);
    chk("t3_rx_count", n_rxv, 4);

    // Short frame then a good one
    spi_frame(2'b00, 1'b1, 2'b11, 8'h12, 8'h34, 10, -1);
    chk("t4_frame_err", n_ferr, 1);
    chk("t4_rx_count", n_rxv, 4);
    spi_frame(2'b00, 1'b1, 2'b01, 8'h81, 8'h7E, NB, -1);
    chk("t4_rx_count_after", n_rxv, 5);

    // Reset mid-frame, then a good one
    spi_frame(2'b01, 1'b1, 2'b01, 8'h77, 8'h88, NB, 7);
    chk("t5_rx_count", n_rxv, 5);
    chk("t5_frame_err", n_ferr, 1);
    spi_frame(2'b10, 1'b1, 2'b10, 8'h44, 8'h99, NB, -1);
    chk("t5_rx_count_after", n_rxv, 6);

    // Over-long frame: only the first NB bits count
    spi_frame(2'b00, 1'b1, 2'b10, 8'hA1, 8'hB2, 25, -1);
    chk("t6_rx_count", n_rxv, 7);

    // Extra read frame in mode 01 with a different pattern
    rd_val = 8'h3B;
    spi_frame(2'b01, 1'b0, 2'b00, 8'hE4, 8'h00, NB, -1);
    chk("t7_rx_count", n_rxv, 8);
    chk("t7_rd_count", n_rd, 2);
    chk("final_frame_err", n_ferr, 1);
    chk("exp_q_empty", exp_q.size(), 0);
    chk("rd_q_empty", rd_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
